// File: rtl/spawn_pos_scheduler_pkg.sv
// Shared constants, FSM encoding and LFSR step helpers for the spawn position server.
package spawn_pos_scheduler_pkg;

  localparam int SCR_X_MAX = 640;
  localparam int SCR_Y_MAX = 480;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  // Feedback taps for x^10+x^7+1 and x^9+x^5+1 in a right-shifting register
  localparam int X_TAP = 3;
  localparam int Y_TAP = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [X_W-1:0] lfsr_x_step(input logic [X_W-1:0] x);
    return {x[0] ^ x[X_TAP], x[X_W-1:1]};
  endfunction

  function automatic logic [Y_W-1:0] lfsr_y_step(input logic [Y_W-1:0] y);
    return {y[0] ^ y[Y_TAP], y[Y_W-1:1]};
  endfunction

endpackage

// File: rtl/spawn_pos_scheduler_lfsr_pair.sv
// Paired x/y LFSRs with synchronous seed load; an all-zero seed is forced to 1 so the
// registers can never lock up.
module spawn_lfsr_pair
  import spawn_pos_scheduler_pkg::*;
#(
  parameter logic [X_W-1:0] SEED_X = 10'h2A5,
  parameter logic [Y_W-1:0] SEED_Y = 9'h0C3
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           step,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] w_load_x;
  logic [Y_W-1:0] w_load_y;

  assign w_load_x = (load_x == '0) ? X_W'(1) : load_x;
  assign w_load_y = (load_y == '0) ? Y_W'(1) : load_y;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_x <= SEED_X;
      r_y <= SEED_Y;
    end else if (load) begin
      r_x <= w_load_x;
      r_y <= w_load_y;
    end else if (step) begin
      r_x <= lfsr_x_step(r_x);
      r_y <= lfsr_y_step(r_y);
    end
  end

  assign x = r_x;
  assign y = r_y;

endmodule

// File: rtl/spawn_pos_scheduler.sv
// Round-robin random-position server: grants one requester at a time an on-screen
// (x,y) drawn from the LFSR pair, retrying out-of-range samples before folding them.
module spawn_pos_scheduler
  import spawn_pos_scheduler_pkg::*;
#(
  parameter int             NUM_REQ   = 4,
  parameter int             ID_W      = 2,
  parameter int             X_MAX     = SCR_X_MAX,
  parameter int             Y_MAX     = SCR_Y_MAX,
  parameter int             MAX_TRIES = 8,
  parameter logic [X_W-1:0] SEED_X    = 10'h2A5,
  parameter logic [Y_W-1:0] SEED_Y    = 9'h0C3
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_load,
  input  logic [X_W-1:0]     seed_x,
  input  logic [Y_W-1:0]     seed_y,
  output logic [NUM_REQ-1:0] ack,
  output logic [ID_W-1:0]    grant_id,
  output logic [X_W-1:0]     pos_x,
  output logic [Y_W-1:0]     pos_y,
  output logic               pos_valid,
  output logic               fallback,
  output logic               busy
);

  localparam int             TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [X_W:0]   X_LIM = X_MAX[X_W:0];
  localparam logic [Y_W:0]   Y_LIM = Y_MAX[Y_W:0];
  localparam logic [ID_W:0]  N_LIM = NUM_REQ[ID_W:0];

  state_t             r_state;
  logic [NUM_REQ-1:0] r_ack;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [TRY_W-1:0]   r_tries;
  logic [X_W-1:0]     r_pos_x;
  logic [Y_W-1:0]     r_pos_y;
  logic               r_pos_valid;
  logic               r_fallback;
  logic               r_busy;

  logic [X_W-1:0]     w_lfsr_x;
  logic [Y_W-1:0]     w_lfsr_y;
  logic               w_step;
  logic               w_load;
  logic               w_grant_found;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W:0]      w_rr_sum;
  logic [ID_W-1:0]    w_rr_idx;
  logic [TRY_W-1:0]   w_tries_inc;
  logic               w_last_try;
  logic               w_in_range;
  logic               w_x_over;
  logic               w_y_over;
  logic [X_W-1:0]     w_fb_x;
  logic [Y_W-1:0]     w_fb_y;
  logic [ID_W-1:0]    w_ptr_next;

  assign w_step = (r_state == ST_DRAW);
  assign w_load = (r_state == ST_IDLE) && seed_load;

  spawn_lfsr_pair #(
    .SEED_X (SEED_X),
    .SEED_Y (SEED_Y)
  ) u_lfsr (
    .clk    (clk),
    .clr_n  (clr_n),
    .step   (w_step),
    .load   (w_load),
    .load_x (seed_x),
    .load_y (seed_y),
    .x      (w_lfsr_x),
    .y      (w_lfsr_y)
  );

  // Scan from the highest offset down so the nearest set bit at/after the pointer wins
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_rr_sum      = '0;
    w_rr_idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_rr_sum = {1'b0, r_rr_ptr} + i[ID_W:0];
      if (w_rr_sum >= N_LIM) begin
        w_rr_sum = w_rr_sum - N_LIM;
      end
      w_rr_idx = w_rr_sum[ID_W-1:0];
      if (req[w_rr_idx]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_rr_idx;
      end
    end
  end

  assign w_tries_inc = r_tries + TRY_W'(1);
  assign w_last_try  = (w_tries_inc == TRY_W'(MAX_TRIES));
  assign w_x_over    = ({1'b0, w_lfsr_x} >= X_LIM);
  assign w_y_over    = ({1'b0, w_lfsr_y} >= Y_LIM);
  assign w_in_range  = !w_x_over && !w_y_over;
  assign w_fb_x      = w_x_over ? {1'b0, w_lfsr_x[X_W-2:0]} : w_lfsr_x;
  assign w_fb_y      = w_y_over ? (w_lfsr_y - Y_W'(256)) : w_lfsr_y;
  assign w_ptr_next  = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state     <= ST_IDLE;
      r_ack       <= '0;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_tries     <= '0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_pos_valid <= 1'b0;
      r_fallback  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A seed write takes this cycle; any pending request is picked up next cycle
          if (!seed_load && w_grant_found) begin
            r_grant_id <= w_grant_idx;
            r_tries    <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          r_tries <= w_tries_inc;
          if (w_in_range || w_last_try) begin
            r_pos_x     <= w_in_range ? w_lfsr_x : w_fb_x;
            r_pos_y     <= w_in_range ? w_lfsr_y : w_fb_y;
            r_fallback  <= !w_in_range;
            r_ack       <= NUM_REQ'(1) << r_grant_id;
            r_pos_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_ack       <= '0;
          r_pos_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_rr_ptr    <= w_ptr_next;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign grant_id  = r_grant_id;
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign pos_valid = r_pos_valid;
  assign fallback  = r_fallback;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spawn_pos_scheduler.sv
// Directed bench for spawn_pos_scheduler: default instance plus a MAX_TRIES=1 instance
// used to exercise the fold-into-range path.
module tb_spawn_pos_scheduler;

  logic       clk;
  logic       clr_n;
  logic [3:0] req;
  logic       seed_load;
  logic [9:0] seed_x;
  logic [8:0] seed_y;
  logic [3:0] ack;
  logic [1:0] grant_id;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic       pos_valid;
  logic       fallback;
  logic       busy;

  logic [3:0] req_fb;
  logic       seed_load_fb;
  logic [9:0] seed_x_fb;
  logic [8:0] seed_y_fb;
  logic [3:0] ack_fb;
  logic [1:0] grant_id_fb;
  logic [9:0] pos_x_fb;
  logic [8:0] pos_y_fb;
  logic       pos_valid_fb;
  logic       fallback_fb;
  logic       busy_fb;

  int n_cmp = 0;
  int n_mis = 0;

  spawn_pos_scheduler u_dut (
    .clk(clk), .clr_n(clr_n), .req(req), .seed_load(seed_load),
    .seed_x(seed_x), .seed_y(seed_y), .ack(ack), .grant_id(grant_id),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .fallback(fallback), .busy(busy)
  );

  spawn_pos_scheduler #(.MAX_TRIES(1)) u_dut_fb (
    .clk(clk), .clr_n(clr_n), .req(req_fb), .seed_load(seed_load_fb),
    .seed_x(seed_x_fb), .seed_y(seed_y_fb), .ack(ack_fb), .grant_id(grant_id_fb),
    .pos_x(pos_x_fb), .pos_y(pos_y_fb), .pos_valid(pos_valid_fb),
    .fallback(fallback_fb), .busy(busy_fb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bounded wait for pos_valid; reports how many edges it took
  task automatic wait_valid(input bit use_fb, input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int c = 1; c <= max_cyc && !seen; c++) begin
      @(posedge clk);
      #1;
      if ((use_fb ? pos_valid_fb : pos_valid) === 1'b1) begin
        seen = 1'b1;
        cyc  = c;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit seen;
    req = 4'b1111;
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ack, pos_valid, busy, fallback} !== 7'd0) begin
      $display("FAIL reset_ctrl: ack/valid/busy/fb=%b required 0", {ack, pos_valid, busy, fallback});
      n_mis++;
    end
    n_cmp++;
    if ({pos_x, pos_y, grant_id} !== 21'd0) begin
      $display("FAIL reset_data: x=%0d y=%0d id=%0d required 0", pos_x, pos_y, grant_id);
      n_mis++;
    end
    n_cmp++;
    if ({ack_fb, pos_valid_fb, busy_fb, fallback_fb, pos_x_fb, pos_y_fb} !== 26'd0) begin
      $display("FAIL reset_fb: outputs not zero");
      n_mis++;
    end
    clr_n = 1'b1;
    wait_valid(1'b0, 20, cyc, seen);
    n_cmp++;
    if (!seen || cyc != 4) begin
      $display("FAIL reset_first_lat: seen=%0d cyc=%0d required 4", seen, cyc);
      n_mis++;
    end
    n_cmp++;
    if (grant_id !== 2'd0 || ack !== 4'b0001) begin
      $display("FAIL reset_first_id: id=%0d ack=%b required 0/0001", grant_id, ack);
      n_mis++;
    end
    n_cmp++;
    if (pos_x !== 10'd425 || pos_y !== 9'd432 || fallback !== 1'b0) begin
      $display("FAIL reset_first_pos: x=%0d y=%0d fb=%b required 425 432 0", pos_x, pos_y, fallback);
      n_mis++;
    end
    $display("reset: grant id=%0d pos=(%0d,%0d) after %0d cycles", grant_id, pos_x, pos_y, cyc);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_accept();
    int cyc;
    bit seen;
    seed_load = 1'b1;
    seed_x = 10'h123;
    seed_y = 9'h0AB;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    req = 4'b0100;
    wait_valid(1'b0, 20, cyc, seen);
    n_cmp++;
    if (!seen || cyc != 2) begin
      $display("FAIL accept_lat: seen=%0d cyc=%0d required 2", seen, cyc);
      n_mis++;
    end
    n_cmp++;
    if (grant_id !== 2'd2 || ack !== 4'b0100) begin
      $display("FAIL accept_id: id=%0d ack=%b required 2/0100", grant_id, ack);
      n_mis++;
    end
    n_cmp++;
    if (pos_x !== 10'd291 || pos_y !== 9'd171 || fallback !== 1'b0) begin
      $display("FAIL accept_pos: x=%0d y=%0d fb=%b required 291 171 0", pos_x, pos_y, fallback);
      n_mis++;
    end
    $display("accept: id=%0d pos=(%0d,%0d) cyc=%0d", grant_id, pos_x, pos_y, cyc);
    req = 4'b0000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (pos_valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || pos_x !== 10'd291 || pos_y !== 9'd171) begin
      $display("FAIL accept_hold: valid=%b ack=%b busy=%b x=%0d y=%0d required 0 0000 0 291 171",
               pos_valid, ack, busy, pos_x, pos_y);
      n_mis++;
    end
  endtask

  task automatic test_seed_defer();
    int cyc;
    bit seen;
    seed_load = 1'b1;
    seed_x = 10'h000;
    seed_y = 9'h000;
    req = 4'b0010;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    wait_valid(1'b0, 20, cyc, seen);
    n_cmp++;
    if (!seen || cyc != 2) begin
      $display("FAIL defer_lat: seen=%0d cyc=%0d required 2 after seed cycle", seen, cyc);
      n_mis++;
    end
    n_cmp++;
    if (grant_id !== 2'd1 || pos_x !== 10'd1 || pos_y !== 9'd1) begin
      $display("FAIL defer_zero_seed: id=%0d x=%0d y=%0d required 1 1 1", grant_id, pos_x, pos_y);
      n_mis++;
    end
    $display("seed_defer: id=%0d pos=(%0d,%0d) cyc=%0d", grant_id, pos_x, pos_y, cyc);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_rejection();
    int cyc;
    bit seen;
    seed_load = 1'b1;
    seed_x = 10'h3FF;
    seed_y = 9'h010;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    req = 4'b0001;
    wait_valid(1'b0, 20, cyc, seen);
    n_cmp++;
    if (!seen || cyc != 3) begin
      $display("FAIL reject_lat: seen=%0d cyc=%0d required 3", seen, cyc);
      n_mis++;
    end
    n_cmp++;
    if (grant_id !== 2'd0 || ack !== 4'b0001 || fallback !== 1'b0) begin
      $display("FAIL reject_id: id=%0d ack=%b fb=%b required 0 0001 0", grant_id, ack, fallback);
      n_mis++;
    end
    n_cmp++;
    if (pos_x !== 10'd511 || pos_y !== 9'd264) begin
      $display("FAIL reject_pos: x=%0d y=%0d required 511 264", pos_x, pos_y);
      n_mis++;
    end
    $display("rejection: id=%0d pos=(%0d,%0d) cyc=%0d", grant_id, pos_x, pos_y, cyc);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_fallback();
    int cyc;
    bit seen;
    seed_load_fb = 1'b1;
    seed_x_fb = 10'h3FF;
    seed_y_fb = 9'h1FF;
    @(posedge clk);
    #1;
    seed_load_fb = 1'b0;
    req_fb = 4'b0010;
    wait_valid(1'b1, 20, cyc, seen);
    n_cmp++;
    if (!seen || cyc != 2) begin
      $display("FAIL fallback_lat: seen=%0d cyc=%0d required 2", seen, cyc);
      n_mis++;
    end
    n_cmp++;
    if (pos_x_fb !== 10'h1FF || pos_y_fb !== 9'h0FF || fallback_fb !== 1'b1) begin
      $display("FAIL fallback_pos: x=%h y=%h fb=%b required 1ff 0ff 1", pos_x_fb, pos_y_fb, fallback_fb);
      n_mis++;
    end
    n_cmp++;
    if (grant_id_fb !== 2'd1 || ack_fb !== 4'b0010) begin
      $display("FAIL fallback_id: id=%0d ack=%b required 1/0010", grant_id_fb, ack_fb);
      n_mis++;
    end
    $display("fallback: id=%0d pos=(%h,%h) fb=%b", grant_id_fb, pos_x_fb, pos_y_fb, fallback_fb);
    req_fb = 4'b0000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (fallback_fb !== 1'b1 || pos_valid_fb !== 1'b0) begin
      $display("FAIL fallback_hold: fb=%b valid=%b required 1 0", fallback_fb, pos_valid_fb);
      n_mis++;
    end
    req_fb = 4'b0010;
    wait_valid(1'b1, 20, cyc, seen);
    n_cmp++;
    if (!seen || pos_x_fb !== 10'd511 || pos_y_fb !== 9'd255 || fallback_fb !== 1'b0) begin
      $display("FAIL fallback_clear: seen=%0d x=%0d y=%0d fb=%b required 1 511 255 0",
               seen, pos_x_fb, pos_y_fb, fallback_fb);
      n_mis++;
    end
    $display("fallback_next: id=%0d pos=(%0d,%0d) fb=%b", grant_id_fb, pos_x_fb, pos_y_fb, fallback_fb);
    req_fb = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_draw();
    bit any_valid;
    req = 4'b1000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL middraw_busy: busy=%b required 1", busy);
      n_mis++;
    end
    clr_n = 1'b0;
    req = 4'b0000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || ack !== 4'b0000 || pos_valid !== 1'b0 || grant_id !== 2'd0) begin
      $display("FAIL middraw_reset: busy=%b ack=%b valid=%b id=%0d required 0 0000 0 0",
               busy, ack, pos_valid, grant_id);
      n_mis++;
    end
    clr_n = 1'b1;
    any_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (pos_valid === 1'b1 || ack !== 4'b0000) any_valid = 1'b1;
    end
    n_cmp++;
    if (any_valid) begin
      $display("FAIL middraw_dropped: ack seen for dropped request, required none");
      n_mis++;
    end
    $display("reset_mid_draw: busy=%b id=%0d", busy, grant_id);
  endtask

  task automatic test_round_robin();
    int cyc;
    bit seen;
    logic [1:0] exp_id;
    logic [3:0] exp_ack;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = 2'(k % 4);
      exp_ack = 4'b0001 << exp_id;
      wait_valid(1'b0, 20, cyc, seen);
      n_cmp++;
      if (!seen || grant_id !== exp_id || ack !== exp_ack) begin
        $display("FAIL rr_grant%0d: seen=%0d id=%0d ack=%b required %0d %b", k, seen, grant_id, ack, exp_id, exp_ack);
        n_mis++;
      end
      n_cmp++;
      if (pos_x >= 10'd640 || pos_y >= 9'd480) begin
        $display("FAIL rr_range%0d: x=%0d y=%0d required <640 <480", k, pos_x, pos_y);
        n_mis++;
      end
      if (k == 0) begin
        n_cmp++;
        if (cyc != 4 || pos_x !== 10'd425 || pos_y !== 9'd432) begin
          $display("FAIL rr_reseed: cyc=%0d x=%0d y=%0d required 4 425 432", cyc, pos_x, pos_y);
          n_mis++;
        end
      end
      $display("round_robin: grant %0d id=%0d pos=(%0d,%0d) cyc=%0d", k, grant_id, pos_x, pos_y, cyc);
      if (k == 4) req = 4'b0000;
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || ack !== 4'b0000) begin
        $display("FAIL rr_idle%0d: busy=%b ack=%b required 0 0000", k, busy, ack);
        n_mis++;
      end
      if (k < 4) begin
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
          $display("FAIL rr_regrant%0d: busy=%b required 1", k, busy);
          n_mis++;
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0;
    req = 4'b0000;
    seed_load = 1'b0;
    seed_x = 10'h000;
    seed_y = 9'h000;
    req_fb = 4'b0000;
    seed_load_fb = 1'b0;
    seed_x_fb = 10'h000;
    seed_y_fb = 9'h000;
    test_reset();
    test_accept();
    test_seed_defer();
    test_rejection();
    test_fallback();
    test_reset_mid_draw();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spawn_pos_scheduler.md
Name: spawn_pos_scheduler

Overview:
- Shared random-position server for the VGA game: several sprite or object spawners request an on-screen (x,y) coordinate, and this block grants them one at a time.
- Owns one 10-bit x LFSR and one 9-bit y LFSR and steps them only while serving a request.
- Rejects samples outside the 640x480 visible area, retrying up to MAX_TRIES times before applying a deterministic fallback.
- Sits between the game-logic spawners and the sprite position registers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; equals clog2(NUM_REQ).
- X_MAX, 640, exclusive upper bound on pos_x.
- Y_MAX, 480, exclusive upper bound on pos_y.
- MAX_TRIES, 8, draw attempts before fallback (>=1).
- SEED_X, 10'h2A5, x LFSR reset value (nonzero).
- SEED_Y, 9'h0C3, y LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock.
- clr_n  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  per-requester request level; held until its ack.
- seed_load  in  1  load seed_x/seed_y into the LFSRs; honoured in IDLE only.
- seed_x  in  10  x seed; a value of 0 is replaced by 1.
- seed_y  in  9  y seed; a value of 0 is replaced by 1.
- ack  out  NUM_REQ  one-cycle one-hot pulse to the served requester.
- grant_id  out  ID_W  index of the current or last grantee.
- pos_x  out  10  granted x, always < X_MAX.
- pos_y  out  9  granted y, always < Y_MAX.
- pos_valid  out  1  one-cycle pulse, coincident with ack.
- fallback  out  1  set with pos_valid when the fallback path was used; holds until the next pos_valid.
- busy  out  1  high in DRAW and DONE.

Behaviour:
- Reset (clr_n=0 at a clk edge):
  - State -> IDLE.
  - ack, pos_valid, busy, fallback, pos_x, pos_y, grant_id = 0.
  - LFSRs -> SEED_X / SEED_Y; round-robin pointer = 0; try counter = 0.
  - Reset has priority over every other input, including mid-DRAW/DONE; an in-flight request is then dropped with no ack.
- LFSR update rules (shift right):
  - x_next = {x[0]^x[3], x[9:1]}, polynomial x^10+x^7+1.
  - y_next = {y[0]^y[4], y[8:1]}, polynomial x^9+x^5+1.
  - Both LFSRs step on every DRAW cycle and hold in all other states.
  - seed_load in IDLE writes the seeds, with zero replaced by 1; seed_load in any other state is ignored.
  - If seed_load and a request both arrive in IDLE, the seed is written and the request is deferred one cycle.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the round-robin pointer (wrapping).
  - Register grant_id, clear the try counter, go to DRAW. busy=1 from the next cycle.
- DRAW (one cycle per attempt):
  - Sample the current LFSR values (before stepping), then increment tries.
  - Accept if x<X_MAX and y<Y_MAX: capture pos_x=x, pos_y=y, fallback=0, go to DONE.
  - Else, if tries==MAX_TRIES: capture pos_x = (x>=X_MAX) ? {1'b0,x[8:0]} : x, and pos_y = (y>=Y_MAX) ? y-256 : y; fallback=1; go to DONE.
  - Else stay in DRAW.
- DONE (one cycle):
  - ack[grant_id]=1, pos_valid=1.
  - Round-robin pointer = grant_id+1 mod NUM_REQ.
  - Go to IDLE.
- Latency:
  - Request first seen in IDLE at edge t gives ack/pos_valid during cycle t+2 (best case).
  - Worst case is t+1+MAX_TRIES.
  - Back-to-back requests see 1 IDLE cycle between grants.
- Requests:
  - A req dropped after grant still completes; its ack is harmless.
  - New req bits arriving mid-service wait for IDLE.
- Outputs pos_x, pos_y, grant_id and fallback hold between grants.

Decomposition:
- Shared package: X_MAX/Y_MAX screen constants, the state encoding (IDLE, DRAW, DONE), and the tap positions.
- One sub-module: spawn_lfsr_pair (both LFSRs with step/load/zero-guard).
- Arbiter, FSM and range check stay in the top module.

Test Plan:
- Reset: hold clr_n=0 for 2 cycles with req=4'b1111 -> all outputs 0, no ack; first grant after release is id 0.
- Accept on first draw: seed_load with x=10'h123, y=9'h0AB; next cycle req=4'b0100 -> grant_id=2; ack=4'b0100 and pos_valid 2 cycles later; pos_x=291, pos_y=171, fallback=0.
- Rejection: seed x=10'h3FF (1023), y=9'h010, req[0] -> first draw rejected; ack at cycle t+3 or later; pos matches the first in-range tap-model state; both positions are in range.
- Fallback: MAX_TRIES=1, seed x=10'h3FF, y=9'h1FF, req[1] -> pos_x=10'h1FF, pos_y=9'h0FF, fallback=1, ack at t+2.
- Round-robin: req=4'b1111 held continuously -> acks to ids 0,1,2,3,0 in order, each separated by one IDLE cycle.
- Reset mid-DRAW: pulse clr_n=0 on the DRAW cycle -> no ack, busy=0, LFSRs equal SEED_X/SEED_Y, pointer=0.
